sum_bcd_display: RTL
====================

// Module: sum_bcd_display
// PURPOSE
//   Display-side consumer of the 9-bit adder result: captures a binary sum,
//   converts it to BCD with a sequential shift-add-3 (double dabble) engine,
//   and drives a time-multiplexed, active-low 7-segment display with
//   leading-zero blanking. Sits between the adder output and the board display.
// PARAMETERS
//   WIDTH       9      binary input width; max value 2^WIDTH-1 = 511
//   DIGITS      3      BCD digits / display positions; must cover 2^WIDTH-1
//   REFRESH_DIV 50000  clock cycles each digit stays lit (>=1)
// PORTS
//   clk    in   1          single system clock, all logic on rising edge
//   rst    in   1          synchronous, active-high reset
//   start  in   1          1-cycle request: capture value, begin conversion
//   value  in   WIDTH      binary sum to convert (sampled only with accepted start)
//   busy   out  1          high while a conversion is in progress
//   done   out  1          1-cycle pulse: new bcd valid
//   bcd    out  4*DIGITS   held BCD result, digit 0 = units in [3:0]
//   seg    out  7          {g,f,e,d,c,b,a}, active low
//   an     out  DIGITS     digit enables, one-hot active low
// BEHAVIOUR
//   Reset (rst=1 at edge): state IDLE, busy=0, done=0, bcd=0, refresh cnt=0,
//     digit idx=0, an={1..1,0}, seg=7'b1000000 ("0"). rst wins over start.
//   FSM IDLE -> SHIFT -> DONE -> IDLE; busy = (state != IDLE), registered.
//   IDLE: start=1 -> load shift reg {0, value}, go SHIFT, bit counter=0.
//   SHIFT: per cycle, add 3 to each BCD nibble >=5, then shift left 1;
//     exactly WIDTH cycles, then DONE.
//   DONE: bcd <= scratch BCD, done=1 for this single cycle, go IDLE.
//   Latency: start sampled at edge N -> done=1 and new bcd after edge N+WIDTH+1.
//   start while busy (SHIFT/DONE) ignored; no queueing. start in IDLE in the
//     cycle right after DONE is accepted (back-to-back).
//   bcd changes only in DONE or reset; held otherwise.
//   rst mid-conversion: conversion abandoned, no done pulse, bcd=0.
//   Display: refresh cnt counts 0..REFRESH_DIV-1; on wrap digit idx advances
//     0->1->..->DIGITS-1->0. an/seg registered, update with digit idx.
//   Blanking: digit k>0 blanked (its an bit stays 1, seg=7'b1111111) when
//     it and all higher digits are 0; digit 0 always lit.
//   Decode: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//     6=0000010 7=1111000 8=0000000 9=0010000 other=1111111.
//   Display always shows held bcd; conversion in progress does not disturb it.
// TESTING (REFRESH_DIV=4 in bench)
//   1 rst=1 2 cycles -> busy=0 done=0 bcd=12'h000 an=3'b110 seg=7'b1000000.
//   2 value=510 (255+255), start 1 cycle -> done exactly 10 cycles later,
//     1 cycle wide; bcd=12'h510; busy high 10 cycles.
//   3 value=19 -> bcd=12'h019; scan: digit0 seg=0010000 an=110, digit1
//     seg=1111001 an=101, digit2 blanked an=111; each slot 4 cycles.
//   4 value=6 start, then start with value=255 at cycle 3 -> ignored,
//     bcd=12'h006, single done pulse.
//   5 start value=145, rst at 4th SHIFT cycle -> no done, bcd=0; restart
//     value=145 -> bcd=12'h145.
//   6 edges: value=0 -> bcd=000, only digit0 lit "0"; value=511 -> bcd=12'h511;
//     back-to-back start the cycle after done -> second result correct.

Source files
------------

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: binary adder result to BCD via double dabble,
// shown on a multiplexed active-low 7-segment display with blanking.
module sum_bcd_display #(
  parameter int WIDTH       = 9,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int NW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [SW-1:0]   adj;
  logic [NW-1:0]   nb_q, nb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [BW-1:0]   shifted;
  logic            lit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM: load, WIDTH add-3/shift steps, then publish result.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    nb_d    = nb_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    adj     = sr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {{BW{1'b0}}, value};
          nb_d    = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (adj[WIDTH+4*k +: 4] >= 4'd5)
            adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
        end
        sr_d = {adj[SW-2:0], 1'b0};
        nb_d = nb_q + NW'(1);
        if (nb_q == NW'(WIDTH - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = sr_q[SW-1 -: BW];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Display scan: refresh divider, digit index, blanked segment/anode.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IW'(DIGITS - 1))
        idx_d = '0;
      else
        idx_d = idx_q + IW'(1);
    end
    shifted = bcd_d >> {idx_d, 2'b00};
    lit     = (idx_d == '0) || (shifted != '0);
    an_d    = lit ? ~(DIGITS'(1) << idx_d) : '1;
    seg_d   = lit ? seg7(shifted[3:0]) : 7'b1111111;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      nb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      nb_q    <= nb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
